// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    // Fetch stage issues requests; memory answers with ack/rdata.
    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage.sv
// Fetch stage: PC, instruction-memory handshake and the IF/ID pipeline register.
// Handles variable-latency memory, ID stalls (via a one-entry hold buffer) and redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0064,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic [31:0]       pc,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

    state_e      state;
    logic        issue_req;
    logic [31:0] issue_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;

    logic [31:0] pc_next;
    logic [31:0] target;

    // Sequential fetch address and word-aligned redirect target.
    always_comb begin
        pc_next = pc + 32'(PC_STEP);
        target  = {redirect_pc[31:2], 2'b00};
    end

    assign imem.req  = issue_req;
    assign imem.addr = issue_addr;

    // Fetch FSM: the request and address are registered so they stay stable until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            issue_req   <= 1'b0;
            issue_addr  <= RESET_PC;
            hold_instr  <= '0;
            hold_pc4    <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    state     <= StReq;
                    issue_req <= 1'b1;
                    if (redirect_valid) begin
                        pc          <= target;
                        issue_addr  <= target;
                        if_id_valid <= 1'b0;
                    end else begin
                        issue_addr <= pc;
                    end
                end
                StReq: begin
                    if (redirect_valid) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                        if (imem.ack) begin
                            // Returned word belongs to the wrong path; refetch at target.
                            issue_addr <= target;
                        end else begin
                            // Request cannot be withdrawn; wait for it and throw it away.
                            state <= StDrop;
                        end
                    end else if (imem.ack) begin
                        pc <= pc_next;
                        if (stall) begin
                            hold_instr <= imem.rdata;
                            hold_pc4   <= pc_next;
                            issue_req  <= 1'b0;
                            state      <= StHold;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem.rdata;
                            if_id_pc4   <= pc_next;
                            issue_addr  <= pc_next;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                StHold: begin
                    if (redirect_valid) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                        hold_instr  <= '0;
                        hold_pc4    <= '0;
                        issue_req   <= 1'b1;
                        issue_addr  <= target;
                        state       <= StReq;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= hold_instr;
                        if_id_pc4   <= hold_pc4;
                        issue_req   <= 1'b1;
                        issue_addr  <= pc;
                        state       <= StReq;
                    end
                end
                StDrop: begin
                    if (redirect_valid) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                    end
                    if (imem.ack) begin
                        issue_addr <= redirect_valid ? target : pc;
                        state      <= StReq;
                    end
                end
                default: begin
                    state     <= StIdle;
                    issue_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns ~addr, ack is driven per-cycle by the stimulus.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        ack_drv;

    int errors = 0;
    int checks = 0;

    if_stage_if imem ();

    assign imem.ack   = ack_drv;
    assign imem.rdata = ~imem.addr;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .pc             (pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if_id(input string tag, input logic v, input logic [31:0] instr,
                               input logic [31:0] pc4);
        check_eq({tag, ".valid"}, 32'(if_id_valid), 32'(v));
        check_eq({tag, ".instr"}, if_id_instr, instr);
        check_eq({tag, ".pc4"}, if_id_pc4, pc4);
    endtask

    task automatic check_bus(input string tag, input logic r, input logic [31:0] a);
        check_eq({tag, ".req"}, 32'(imem.req), 32'(r));
        if (r) check_eq({tag, ".addr"}, imem.addr, a);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ack_drv = 1'b0;

        // 1: reset
        step(); step();
        rst = 1'b0;
        check_eq("rst.pc", pc, 32'h64);
        check_bus("rst", 1'b0, 32'h0);
        check_if_id("rst", 1'b0, 32'h0, 32'h0);
        step();
        check_bus("first_req", 1'b1, 32'h64);

        // 2: zero-wait memory, one instruction per cycle
        ack_drv = 1'b1;
        step();
        check_if_id("zw0", 1'b1, ~32'h64, 32'h68);
        step();
        check_if_id("zw1", 1'b1, ~32'h68, 32'h6C);
        step();
        check_if_id("zw2", 1'b1, ~32'h6C, 32'h70);
        check_bus("zw2", 1'b1, 32'h70);

        // Restart for the latency/stall/redirect sequence.
        rst = 1'b1; ack_drv = 1'b0;
        step();
        rst = 1'b0;
        step();
        ack_drv = 1'b1;
        step();
        check_if_id("seq64", 1'b1, ~32'h64, 32'h68);

        // 3: ack delayed 3 cycles at 0x68
        ack_drv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bus($sformatf("wait%0d", i), 1'b1, 32'h68);
            check_eq($sformatf("wait%0d.valid", i), 32'(if_id_valid), 32'd0);
        end
        ack_drv = 1'b1;
        step();
        check_if_id("late68", 1'b1, ~32'h68, 32'h6C);
        check_bus("late68", 1'b1, 32'h6C);

        // 4: stall in ack cycle for 0x6C, held 2 cycles
        stall = 1'b1;
        step();
        check_if_id("stall0", 1'b1, ~32'h68, 32'h6C);
        check_bus("stall0", 1'b0, 32'h0);
        step();
        check_if_id("stall1", 1'b1, ~32'h68, 32'h6C);
        check_bus("stall1", 1'b0, 32'h0);
        stall = 1'b0; ack_drv = 1'b0;
        step();
        check_if_id("release", 1'b1, ~32'h6C, 32'h70);
        check_bus("release", 1'b1, 32'h70);
        ack_drv = 1'b1;
        step();
        check_if_id("f70", 1'b1, ~32'h70, 32'h74);

        // 5: redirect while 0x74 is outstanding and unacked
        ack_drv = 1'b0;
        step();
        check_bus("pend74", 1'b1, 32'h74);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        check_eq("redir.valid", 32'(if_id_valid), 32'd0);
        check_eq("redir.pc", pc, 32'h200);
        check_bus("drop", 1'b1, 32'h74);
        ack_drv = 1'b1;
        step();
        check_eq("dropack.valid", 32'(if_id_valid), 32'd0);
        check_eq("dropack.instr", if_id_instr, ~32'h70);
        check_bus("dropack", 1'b1, 32'h200);
        step();
        check_if_id("f200", 1'b1, ~32'h200, 32'h204);

        // 6: reset while holding a stalled instruction
        stall = 1'b1;
        step();
        check_bus("hold", 1'b0, 32'h0);
        rst = 1'b1;
        step();
        check_eq("rsthold.pc", pc, 32'h64);
        check_if_id("rsthold", 1'b0, 32'h0, 32'h0);
        check_bus("rsthold", 1'b0, 32'h0);
        rst = 1'b0; stall = 1'b0;
        step();
        check_eq("rst_idle.valid", 32'(if_id_valid), 32'd0);
        check_bus("rst_idle", 1'b1, 32'h64);
        step();
        check_if_id("after_rst", 1'b1, ~32'h64, 32'h68);

        // Redirect coinciding with ack, then wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_ack.valid", 32'(if_id_valid), 32'd0);
        check_bus("redir_ack", 1'b1, 32'hFFFF_FFFC);
        step();
        check_if_id("wrap", 1'b1, ~32'hFFFF_FFFC, 32'h0);
        check_eq("wrap.pc", pc, 32'h0);
        check_bus("wrap", 1'b1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
